pwm_sequencer: RTL and testbench
================================

PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4, is the number of PWM output stages driven (2..8).
REQ-002 Parameter REG_WIDTH, default 32, is the data width of shadow registers and the stage bus.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cfg_we  input  1  shadow-register write strobe.
REQ-006 cfg_ch  input  3  target channel index; values >= CHANNELS are ignored.
REQ-007 cfg_adr  input  2  shadow register select: 0 = cycle, 1 = on_time, 2 = phase, 3 = reserved and ignored.
REQ-008 cfg_data  input  REG_WIDTH  shadow write data.
REQ-009 commit  input  1  single-cycle request to transfer dirty shadows to the stages.
REQ-010 commit_sync  input  1  sampled with commit; requests a counter-sync step after the transfer.
REQ-011 busy  output  1  high while a commit sequence runs.
REQ-012 done  output  1  one-cycle pulse at the end of a sequence.
REQ-013 stage_sel  output  CHANNELS  one write-select bit per stage.
REQ-014 stage_adr  output  2  stage register address, shared by all stages.
REQ-015 stage_data  output  REG_WIDTH  stage write data, shared by all stages.

Function
REQ-016 Each channel shall hold shadow registers cycle_sh and on_sh, each with a dirty bit.
- cfg_we with cfg_adr 0/1 loads the shadow and sets its dirty bit at the clock edge.
REQ-017 The FSM shall have states IDLE, SCAN, SYNC and DONE.
- Transition: IDLE -> SCAN on commit.
- commit_sync is latched into sync_req at the same edge.
REQ-018 SCAN shall last exactly 2*CHANNELS cycles, visiting slots in order (ch0 cycle, ch0 on, ch1 cycle, ...).
- Dirty slot: drive stage_sel one-hot on the channel, stage_adr 0 or 1, stage_data = shadow value, and clear the dirty bit.
- Clean slot: stage_sel stays all zero.
REQ-019 After SCAN the FSM shall go to SYNC if sync_req is set, else to DONE.
REQ-020 Without PWM_SEQ_PHASE_EN, SYNC shall last 1 cycle: stage_sel all ones, stage_adr 2, stage_data 0.
REQ-021 DONE shall last 1 cycle with done high, then return to IDLE.
REQ-022 busy shall be high in SCAN, SYNC and DONE, and low in IDLE.
REQ-023 Timing: stage_sel/stage_adr/stage_data, busy and done are registered.
- The first SCAN slot appears in the cycle after the edge that samples commit.
- Total sequence length = 2*CHANNELS + S + 1 cycles, with S the SYNC length (0 if none).
REQ-024 commit while busy shall be ignored; it is not queued.
REQ-025 cfg_we is accepted in every state.
- If it hits the slot being scanned in that same cycle: the stage receives the pre-write value and the dirty bit stays set.
REQ-026 A commit with no dirty slots and no sync_req shall still run the full SCAN and DONE with no stage writes.
REQ-027 stage_adr and stage_data shall be 0 whenever stage_sel is all zero.

Reset
REQ-028 reset shall force IDLE and clear sync_req, all shadows and all dirty bits.
- Outputs: busy 0, done 0, stage_sel 0, stage_adr 0, stage_data 0.
- This holds in any state, including mid-sequence; no further stage writes are issued after reset.

Configuration
REQ-029 Macro PWM_SEQ_PHASE_EN shall add a per-channel phase_sh shadow, written via cfg_adr 2.
- Without the macro, cfg_adr 2 writes are ignored.
REQ-030 With PWM_SEQ_PHASE_EN, SYNC shall last CHANNELS cycles; in SYNC cycle k it drives stage_sel bit k, stage_adr 2, and stage_data = phase_sh[k] - (CHANNELS-1-k) mod 2^REG_WIDTH.
- Effect: every counter equals its phase_sh in the cycle after SYNC.
- Phases below CHANNELS-1 wrap and are the software's responsibility.

Verification
REQ-031 Defaults. Write ch1 cycle=99, ch1 on=25, then commit -> SCAN slots 2,3 drive stage_sel=0010, adr 0 data 99, then adr 1 data 25; done in cycle 9; busy high in cycles 1..9.
REQ-032 Commit with commit_sync=1, macro off, no dirty slots -> no writes in cycles 1..8; cycle 9 stage_sel=1111 adr 2 data 0; done in cycle 10.
REQ-033 Macro on. Phases 10,20,30,40, commit_sync=1 -> SYNC data 7,18,29,40 on sel 0001,0010,0100,1000; done in cycle 13.
REQ-034 cfg_we ch0 on=5 in the same cycle ch0 on is scanned (prior value 3) -> stage gets 3; the next commit writes 5.
REQ-035 A second commit in cycle 4 is ignored (only one done pulse); reset asserted in cycle 5 gives all outputs 0 in the next cycle, and a following commit writes nothing.

Source files
------------

// File: rtl/pwm_sequencer.sv
// PWM commit sequencer: per-channel shadow registers are streamed onto a shared stage bus on commit.
// Optional build macro PWM_SEQ_PHASE_EN adds phase shadows and a per-channel phase-aligned sync step.
module pwm_sequencer #(
   parameter int CHANNELS  = 4,
   parameter int REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_ch,
   input  logic [1:0]           cfg_adr,
   input  logic [REG_WIDTH-1:0] cfg_data,
   input  logic                 commit,
   input  logic                 commit_sync,
   output logic                 busy,
   output logic                 done,
   output logic [CHANNELS-1:0]  stage_sel,
   output logic [1:0]           stage_adr,
   output logic [REG_WIDTH-1:0] stage_data
);

   localparam int SLOTS  = 2 * CHANNELS;
   localparam int SLOT_W = $clog2(SLOTS);

   typedef enum logic [1:0] {IDLE, SCAN, SYNC, DONE} state_e;

   state_e               state_q, state_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic                 sync_req_q, sync_req_d;
   logic                 busy_q, done_q;
   logic [CHANNELS-1:0]  sel_q, sel_d;
   logic [1:0]           adr_q, adr_d;
   logic [REG_WIDTH-1:0] data_q, data_d;

   logic [REG_WIDTH-1:0] cycle_sh_q [CHANNELS];
   logic [REG_WIDTH-1:0] on_sh_q    [CHANNELS];
   logic [CHANNELS-1:0]  cycle_dirty_q, cycle_dirty_d;
   logic [CHANNELS-1:0]  on_dirty_q, on_dirty_d;
`ifdef PWM_SEQ_PHASE_EN
   logic [REG_WIDTH-1:0] phase_sh_q [CHANNELS];
`endif

   logic [CHANNELS-1:0]  cfg_hit, cycle_clr, on_clr;
   logic                 scan_emit, sync_emit;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      slot_d     = slot_q;
      sync_req_d = sync_req_q;
      sel_d      = '0;
      adr_d      = '0;
      data_d     = '0;
      cycle_clr  = '0;
      on_clr     = '0;
      cfg_hit    = '0;
      scan_emit  = 1'b0;
      sync_emit  = 1'b0;

      case (state_q)
         IDLE: if (commit) begin
            state_d    = SCAN;
            slot_d     = '0;
            sync_req_d = commit_sync;
            scan_emit  = 1'b1;
         end
         SCAN: if (slot_q == SLOT_W'(SLOTS - 1)) begin
            if (sync_req_q) begin
               state_d   = SYNC;
               slot_d    = '0;
               sync_emit = 1'b1;
            end else begin
               state_d = DONE;
            end
         end else begin
            slot_d    = slot_q + SLOT_W'(1);
            scan_emit = 1'b1;
         end
`ifdef PWM_SEQ_PHASE_EN
         SYNC: if (slot_q == SLOT_W'(CHANNELS - 1)) begin
            state_d = DONE;
         end else begin
            slot_d    = slot_q + SLOT_W'(1);
            sync_emit = 1'b1;
         end
`else
         SYNC: state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs for the slot entered next are built from the shadows as they stand before this edge.
      if (scan_emit) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (slot_d[SLOT_W-1:1] == (SLOT_W-1)'(c)) begin
               if (!slot_d[0] && cycle_dirty_q[c]) begin
                  sel_d[c]     = 1'b1;
                  adr_d        = 2'd0;
                  data_d       = cycle_sh_q[c];
                  cycle_clr[c] = 1'b1;
               end
               if (slot_d[0] && on_dirty_q[c]) begin
                  sel_d[c]  = 1'b1;
                  adr_d     = 2'd1;
                  data_d    = on_sh_q[c];
                  on_clr[c] = 1'b1;
               end
            end
         end
      end

      if (sync_emit) begin
`ifdef PWM_SEQ_PHASE_EN
         // Stage k is loaded early, so pre-subtract the cycles it will count before SYNC ends.
         for (int c = 0; c < CHANNELS; c++) begin
            if (slot_d == SLOT_W'(c)) begin
               sel_d[c] = 1'b1;
               adr_d    = 2'd2;
               data_d   = phase_sh_q[c] - REG_WIDTH'(CHANNELS - 1 - c);
            end
         end
`else
         sel_d  = '1;
         adr_d  = 2'd2;
         data_d = '0;
`endif
      end

      for (int c = 0; c < CHANNELS; c++) begin
         cfg_hit[c] = cfg_we && (cfg_ch == 3'(c));
      end
      // A write landing on the slot just scanned re-arms its dirty bit.
      cycle_dirty_d = (cycle_dirty_q & ~cycle_clr) | (cfg_hit & {CHANNELS{cfg_adr == 2'd0}});
      on_dirty_d    = (on_dirty_q & ~on_clr)       | (cfg_hit & {CHANNELS{cfg_adr == 2'd1}});
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         slot_q        <= '0;
         sync_req_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         sel_q         <= '0;
         adr_q         <= '0;
         data_q        <= '0;
         cycle_dirty_q <= '0;
         on_dirty_q    <= '0;
         // NOTE: the shadow arrays are reset here because stale values must never be committed after reset.
         for (int c = 0; c < CHANNELS; c++) begin
            cycle_sh_q[c] <= '0;
            on_sh_q[c]    <= '0;
`ifdef PWM_SEQ_PHASE_EN
            phase_sh_q[c] <= '0;
`endif
         end
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         sync_req_q    <= sync_req_d;
         busy_q        <= (state_d != IDLE);
         done_q        <= (state_d == DONE);
         sel_q         <= sel_d;
         adr_q         <= adr_d;
         data_q        <= data_d;
         cycle_dirty_q <= cycle_dirty_d;
         on_dirty_q    <= on_dirty_d;
         for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_hit[c]) begin
               case (cfg_adr)
                  2'd0: cycle_sh_q[c] <= cfg_data;
                  2'd1: on_sh_q[c]    <= cfg_data;
`ifdef PWM_SEQ_PHASE_EN
                  2'd2: phase_sh_q[c] <= cfg_data;
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign stage_sel  = sel_q;
   assign stage_adr  = adr_q;
   assign stage_data = data_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: sequence-position reference model plus directed literal checks.
// Define PWM_SEQ_PHASE_EN for bench and RTL together to exercise the phase-aligned sync step.
module tb_pwm_sequencer;

   localparam int C = 4;
   localparam int W = 32;
`ifdef PWM_SEQ_PHASE_EN
   localparam int SYNC_LEN = C;
`else
   localparam int SYNC_LEN = 1;
`endif

   logic         clk = 1'b0;
   logic         reset, cfg_we, commit, commit_sync;
   logic [2:0]   cfg_ch;
   logic [1:0]   cfg_adr;
   logic [W-1:0] cfg_data;
   logic         busy, done;
   logic [C-1:0] stage_sel;
   logic [1:0]   stage_adr;
   logic [W-1:0] stage_data;

   pwm_sequencer #(.CHANNELS(C), .REG_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_adr    (cfg_adr),
      .cfg_data   (cfg_data),
      .commit     (commit),
      .commit_sync(commit_sync),
      .busy       (busy),
      .done       (done),
      .stage_sel  (stage_sel),
      .stage_adr  (stage_adr),
      .stage_data (stage_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: position n counts cycles since the commit edge; length L = 2C + S + 1.
   int           m_n = 0;
   int           m_len = 0;
   logic [W-1:0] m_cyc [C];
   logic [W-1:0] m_on  [C];
   logic [W-1:0] m_ph  [C];
   bit           m_cyc_dirty [C];
   bit           m_on_dirty  [C];
   logic         exp_busy = 1'b0, exp_done = 1'b0;
   logic [C-1:0] exp_sel = '0;
   logic [1:0]   exp_adr = '0;
   logic [W-1:0] exp_data = '0;
   bit           cmp_en = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         exp_sel  = '0;
         exp_adr  = '0;
         exp_data = '0;
         if (reset) begin
            m_n = 0;
            for (int c = 0; c < C; c++) begin
               m_cyc[c] = '0; m_on[c] = '0; m_ph[c] = '0;
               m_cyc_dirty[c] = 1'b0; m_on_dirty[c] = 1'b0;
            end
         end else begin
            if (m_n == 0) begin
               if (commit) begin
                  m_n   = 1;
                  m_len = 2 * C + (commit_sync ? SYNC_LEN : 0) + 1;
               end
            end else if (m_n == m_len) begin
               m_n = 0;
            end else begin
               m_n++;
            end
            if (m_n >= 1 && m_n <= 2 * C) begin
               int slot, ch;
               slot = m_n - 1;
               ch   = slot / 2;
               if (slot % 2 == 0 && m_cyc_dirty[ch]) begin
                  exp_sel[ch] = 1'b1; exp_adr = 2'd0; exp_data = m_cyc[ch];
                  m_cyc_dirty[ch] = 1'b0;
               end else if (slot % 2 == 1 && m_on_dirty[ch]) begin
                  exp_sel[ch] = 1'b1; exp_adr = 2'd1; exp_data = m_on[ch];
                  m_on_dirty[ch] = 1'b0;
               end
            end else if (m_n > 2 * C && m_n < m_len) begin
`ifdef PWM_SEQ_PHASE_EN
               int k;
               k = m_n - 2 * C - 1;
               exp_sel[k] = 1'b1;
               exp_adr    = 2'd2;
               exp_data   = m_ph[k] - W'(C - 1 - k);
`else
               exp_sel  = '1;
               exp_adr  = 2'd2;
               exp_data = '0;
`endif
            end
            if (cfg_we && int'(cfg_ch) < C) begin
               case (cfg_adr)
                  2'd0: begin m_cyc[cfg_ch] = cfg_data; m_cyc_dirty[cfg_ch] = 1'b1; end
                  2'd1: begin m_on[cfg_ch]  = cfg_data; m_on_dirty[cfg_ch]  = 1'b1; end
`ifdef PWM_SEQ_PHASE_EN
                  2'd2: m_ph[cfg_ch] = cfg_data;
`endif
                  default: ;
               endcase
            end
         end
         exp_busy = (m_n != 0);
         exp_done = (m_n != 0) && (m_n == m_len);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("model_busy", busy, exp_busy);
            check("model_done", done, exp_done);
            check("model_sel", stage_sel, exp_sel);
            check("model_adr", stage_adr, exp_adr);
            check("model_data", stage_data, exp_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   logic [C-1:0] cap_sel  [32];
   logic [1:0]   cap_adr  [32];
   logic [W-1:0] cap_data [32];
   logic         cap_busy [32];
   logic         cap_done [32];

   task automatic cfg_write(input int ch, input int adr, input logic [W-1:0] d);
      cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_adr = 2'(adr); cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Commit in the current cycle (cycle 0) and capture outputs of cycles 1..ncyc; events fire in the named cycle.
   task automatic run_seq(input logic sync, input int ncyc, input int commit_at, input int reset_at, input int wr_at);
      commit = 1'b1; commit_sync = sync;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         commit = 1'b0; commit_sync = 1'b0; cfg_we = 1'b0; reset = 1'b0;
         cap_sel[n] = stage_sel; cap_adr[n] = stage_adr; cap_data[n] = stage_data;
         cap_busy[n] = busy; cap_done[n] = done;
         if (n == commit_at) commit = 1'b1;
         if (n == reset_at) reset = 1'b1;
         if (n == wr_at) begin
            cfg_we = 1'b1; cfg_ch = 3'd0; cfg_adr = 2'd1; cfg_data = 5;
         end
      end
   endtask

   int cnt;

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_adr = '0; cfg_data = '0;
      commit = 1'b0; commit_sync = 1'b0;
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sel", stage_sel, 0);
      check("reset_adr", stage_adr, 0);
      check("reset_data", stage_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // Two dirty slots on channel 1, no sync.
      cfg_write(1, 0, 99);
      cfg_write(1, 1, 25);
      run_seq(1'b0, 11, 0, 0, 0);
      check("t1_idle_slot_sel", cap_sel[1], 0);
      check("t1_cyc_sel", cap_sel[3], 4'b0010);
      check("t1_cyc_adr", cap_adr[3], 0);
      check("t1_cyc_data", cap_data[3], 99);
      check("t1_on_sel", cap_sel[4], 4'b0010);
      check("t1_on_adr", cap_adr[4], 1);
      check("t1_on_data", cap_data[4], 25);
      check("t1_done_c8", cap_done[8], 0);
      check("t1_done_c9", cap_done[9], 1);
      cnt = 0;
      for (int n = 1; n <= 11; n++) if (cap_busy[n]) cnt++;
      check("t1_busy_cycles", cnt, 9);
      check("t1_busy_c10", cap_busy[10], 0);
      @(negedge clk);

      // Writes that must be ignored: channel out of range, reserved address, phase with macro off.
      cfg_write(5, 0, 123);
      cfg_write(0, 3, 77);
      cfg_write(2, 2, 55);
      run_seq(1'b1, 14, 0, 0, 0);
`ifndef PWM_SEQ_PHASE_EN
      cnt = 0;
      for (int n = 1; n <= 8; n++) if (cap_sel[n] != 0) cnt++;
      check("t2_no_scan_writes", cnt, 0);
      check("t2_sync_sel", cap_sel[9], 4'b1111);
      check("t2_sync_adr", cap_adr[9], 2);
      check("t2_sync_data", cap_data[9], 0);
      check("t2_done_c9", cap_done[9], 0);
      check("t2_done_c10", cap_done[10], 1);
`endif
      @(negedge clk);

`ifdef PWM_SEQ_PHASE_EN
      cfg_write(0, 2, 10);
      cfg_write(1, 2, 20);
      cfg_write(2, 2, 30);
      cfg_write(3, 2, 40);
      run_seq(1'b1, 15, 0, 0, 0);
      check("t3_sel_k0", cap_sel[9], 4'b0001);
      check("t3_data_k0", cap_data[9], 7);
      check("t3_sel_k1", cap_sel[10], 4'b0010);
      check("t3_data_k1", cap_data[10], 18);
      check("t3_sel_k2", cap_sel[11], 4'b0100);
      check("t3_data_k2", cap_data[11], 29);
      check("t3_sel_k3", cap_sel[12], 4'b1000);
      check("t3_data_k3", cap_data[12], 40);
      check("t3_adr", cap_adr[12], 2);
      check("t3_done_c13", cap_done[13], 1);
      @(negedge clk);
`endif

      // Write colliding with the slot being scanned: stage sees the old value, next commit the new one.
      cfg_write(0, 1, 3);
      run_seq(1'b0, 11, 0, 0, 2);
      check("t4_collide_sel", cap_sel[2], 4'b0001);
      check("t4_collide_adr", cap_adr[2], 1);
      check("t4_collide_data", cap_data[2], 3);
      @(negedge clk);
      run_seq(1'b0, 11, 0, 0, 0);
      check("t4_rewrite_sel", cap_sel[2], 4'b0001);
      check("t4_rewrite_data", cap_data[2], 5);
      @(negedge clk);

      // Commit while busy is dropped.
      run_seq(1'b0, 14, 4, 0, 0);
      cnt = 0;
      for (int n = 1; n <= 14; n++) if (cap_done[n]) cnt++;
      check("t5_single_done", cnt, 1);
      check("t5_done_c9", cap_done[9], 1);
      @(negedge clk);

      // Reset mid-sequence with a dirty slot still pending.
      cfg_write(3, 1, 32'hAB);
      run_seq(1'b0, 8, 0, 5, 0);
      check("t5_rst_busy", cap_busy[6], 0);
      check("t5_rst_done", cap_done[6], 0);
      check("t5_rst_sel", cap_sel[6], 0);
      check("t5_rst_adr", cap_adr[6], 0);
      check("t5_rst_data", cap_data[6], 0);
      cnt = 0;
      for (int n = 6; n <= 8; n++) if (cap_sel[n] != 0 || cap_busy[n]) cnt++;
      check("t5_quiet_after_rst", cnt, 0);
      @(negedge clk);
      run_seq(1'b0, 11, 0, 0, 0);
      cnt = 0;
      for (int n = 1; n <= 11; n++) if (cap_sel[n] != 0) cnt++;
      check("t5_post_rst_no_writes", cnt, 0);
      check("t5_post_rst_done", cap_done[9], 1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
